// File: rtl/force_cache_accumulator.sv
// Per-cell force cache: accumulates {fx,fy,fz} partial forces per particle by
// read-modify-write on a 1R1W RAM, with bulk zeroing and a readout port.
module force_cache_accumulator #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int FORCE_CACHE_WIDTH = 3 * DATA_WIDTH,
    parameter int FORCE_DATA_WIDTH  = FORCE_CACHE_WIDTH + PARTICLE_ID_WIDTH,
    parameter int RD_CLEAR          = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FORCE_DATA_WIDTH-1:0]  fc_data_in,
    input  logic                         fc_data_valid,
    input  logic                         clear_req,
    input  logic                         readout_req,
    input  logic                         readout_done,
    input  logic                         rd_en,
    input  logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    output logic [FORCE_CACHE_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    output logic                         accum_ready,
    output logic                         readout_ready,
    output logic                         drop_err,
    output logic [CNT_WIDTH-1:0]         pkt_count
);
    localparam int DEPTH = 2 ** PARTICLE_ID_WIDTH;

    typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, READOUT} state_t;
    state_t state_reg, state_next;

    logic [PARTICLE_ID_WIDTH-1:0] clr_cnt_reg;
    logic [FORCE_CACHE_WIDTH-1:0] mem [DEPTH];
    logic [FORCE_CACHE_WIDTH-1:0] ram_q_reg;
    logic [PARTICLE_ID_WIDTH-1:0] raddr;
    logic                         wr_en;
    logic [PARTICLE_ID_WIDTH-1:0] wr_addr;
    logic [FORCE_CACHE_WIDTH-1:0] wr_data;

    logic                         s1_valid_reg, s2_valid_reg;
    logic [PARTICLE_ID_WIDTH-1:0] s1_id_reg, s2_id_reg;
    logic [FORCE_CACHE_WIDTH-1:0] s1_force_reg, s2_sum_reg;
    logic [FORCE_CACHE_WIDTH-1:0] operand, sum;

    logic                         rd_valid_reg;
    logic [FORCE_CACHE_WIDTH-1:0] rd_hold_reg;
    logic                         drop_err_reg;
    logic [CNT_WIDTH-1:0]         pkt_count_reg;

    logic [PARTICLE_ID_WIDTH-1:0] pkt_id;
    logic [FORCE_CACHE_WIDTH-1:0] pkt_force;
    logic                         accepting, accept, clear_entry, rd_fire;

    assign pkt_id      = fc_data_in[PARTICLE_ID_WIDTH-1:0];
    assign pkt_force   = fc_data_in[FORCE_DATA_WIDTH-1:PARTICLE_ID_WIDTH];
    assign accepting   = (state_reg == ACCUM) || (state_reg == DRAIN);
    assign accept      = fc_data_valid && accepting;
    assign clear_entry = (state_reg != CLEAR) && (state_next == CLEAR);
    assign rd_fire     = (state_reg == READOUT) && rd_en;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR:   if (clr_cnt_reg == {PARTICLE_ID_WIDTH{1'b1}}) state_next = ACCUM;
            ACCUM:   if (clear_req) state_next = CLEAR;
                     else if (readout_req) state_next = DRAIN;
            DRAIN:   if (clear_req) state_next = CLEAR;
                     else if (!s1_valid_reg && !s2_valid_reg && !fc_data_valid) state_next = READOUT;
            READOUT: if (clear_req) state_next = CLEAR;
                     else if (readout_done) state_next = ACCUM;
            default: state_next = CLEAR;
        endcase
    end

    // S2 holds the most recent sum, which the read-first RAM cannot yet return
    assign operand = (s2_valid_reg && (s2_id_reg == s1_id_reg)) ? s2_sum_reg : ram_q_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_comp
            assign sum[gi*DATA_WIDTH +: DATA_WIDTH] =
                operand[gi*DATA_WIDTH +: DATA_WIDTH] + s1_force_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Read-clear zeroes in the strobe cycle; read-first returns the old value
    // and any later read already sees zero.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_cnt_reg;
        wr_data = '0;
        if (state_reg == CLEAR) begin
            wr_en = 1'b1;
        end else if (s1_valid_reg) begin
            wr_en   = 1'b1;
            wr_addr = s1_id_reg;
            wr_data = sum;
        end else if (rd_fire && (RD_CLEAR != 0)) begin
            wr_en   = 1'b1;
            wr_addr = rd_addr;
        end
    end

    assign raddr = (state_reg == READOUT) ? rd_addr : pkt_id;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        ram_q_reg <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= CLEAR;
            clr_cnt_reg   <= '0;
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_hold_reg   <= '0;
            drop_err_reg  <= 1'b0;
            pkt_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= (state_reg == CLEAR) ? clr_cnt_reg + 1'b1 : '0;
            rd_valid_reg <= rd_fire;
            if (rd_valid_reg) rd_hold_reg <= ram_q_reg;
            if (clear_entry) begin
                s1_valid_reg  <= 1'b0;
                s2_valid_reg  <= 1'b0;
                pkt_count_reg <= '0;
                drop_err_reg  <= 1'b0;
            end else begin
                s1_valid_reg <= accept;
                s2_valid_reg <= s1_valid_reg;
                if (accept && (pkt_count_reg != {CNT_WIDTH{1'b1}}))
                    pkt_count_reg <= pkt_count_reg + 1'b1;
                if (fc_data_valid && !accepting) drop_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_id_reg    <= pkt_id;
            s1_force_reg <= pkt_force;
        end
        if (s1_valid_reg) begin
            s2_id_reg  <= s1_id_reg;
            s2_sum_reg <= sum;
        end
    end

    assign rd_data       = rd_valid_reg ? ram_q_reg : rd_hold_reg;
    assign rd_valid      = rd_valid_reg;
    assign accum_ready   = (state_reg == ACCUM);
    assign readout_ready = (state_reg == READOUT);
    assign drop_err      = drop_err_reg;
    assign pkt_count     = pkt_count_reg;
endmodule

// File: tb/tb_force_cache_accumulator.sv
// Directed bench for force_cache_accumulator; readout results are checked
// against a queue of expected entries filled as read strobes are issued.
module tb_force_cache_accumulator;
    logic         clk = 1'b0;
    logic         rst;
    logic [102:0] fc_data_in;
    logic         fc_data_valid, clear_req, readout_req, readout_done, rd_en;
    logic [6:0]   rd_addr;
    logic [95:0]  rd_data;
    logic         rd_valid, accum_ready, readout_ready, drop_err;
    logic [15:0]  pkt_count;

    int checks = 0;
    int failures = 0;
    logic [95:0] sb[$];
    logic [95:0] last_exp;

    force_cache_accumulator dut (
        .clk(clk), .rst(rst), .fc_data_in(fc_data_in), .fc_data_valid(fc_data_valid),
        .clear_req(clear_req), .readout_req(readout_req), .readout_done(readout_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .accum_ready(accum_ready), .readout_ready(readout_ready), .drop_err(drop_err),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [102:0] pkt(input logic [6:0] id, input logic [31:0] fx,
                                         input logic [31:0] fy, input logic [31:0] fz);
        return {fx, fy, fz, id};
    endfunction

    function automatic logic [95:0] f3(input logic [31:0] fx, input logic [31:0] fy,
                                       input logic [31:0] fz);
        return {fx, fy, fz};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd_cycle(input logic [6:0] a, input logic [95:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        sb.push_back(e);
        last_exp = e;
        tick();
    endtask

    task automatic enter_readout();
        readout_req = 1'b1;
        tick();
        readout_req = 1'b0;
        for (int n = 0; n < 16 && !readout_ready; n++) tick();
        check("readout_ready_wait", readout_ready, 1);
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 128; i++) rd_cycle(i[6:0], '0);
        rd_en = 1'b0;
        tick();
    endtask

    // Readout scoreboard: every rd_valid pulse consumes one expected entry
    always @(negedge clk) begin
        if (rst === 1'b0 && rd_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL rd_valid_unexpected observed=1 expected=0");
            end
            if (sb.size() != 0) check("rd_data", rd_data, sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fc_data_in = '0; fc_data_valid = 1'b0; clear_req = 1'b0;
        readout_req = 1'b0; readout_done = 1'b0; rd_en = 1'b0; rd_addr = '0;
        last_exp = '0;
        repeat (3) tick();
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_accum_ready", accum_ready, 0);
        check("rst_readout_ready", readout_ready, 0);
        check("rst_drop_err", drop_err, 0);
        check("rst_pkt_count", pkt_count, 0);

        // Initial clear: 128 write cycles, accum_ready in cycle 129
        rst = 1'b0;
        repeat (127) tick();
        check("clear_cycle128_not_ready", accum_ready, 0);
        tick();
        check("clear_cycle129_ready", accum_ready, 1);
        check("post_clear_drop_err", drop_err, 0);

        enter_readout();
        read_all_zero();
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        check("resume_accum", accum_ready, 1);

        // id 5: two non-consecutive packets
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd5, 32'd1, 32'd2, 32'd3);
        tick();
        fc_data_valid = 1'b0;
        tick();
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd5, 32'd10, 32'd20, 32'd30);
        tick();
        fc_data_valid = 1'b0;
        repeat (2) tick();
        check("pkt_count_2", pkt_count, 2);

        // id 9 every cycle for 4 cycles: forwarding path
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd9, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        repeat (4) tick();
        fc_data_valid = 1'b0;
        repeat (2) tick();
        check("pkt_count_6", pkt_count, 6);

        // readout_req with packets in flight: DRAIN until pipeline empty
        readout_req = 1'b1;
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd20, 32'd5, 32'd6, 32'd7);
        tick();
        readout_req = 1'b0;
        fc_data_in = pkt(7'd20, 32'd1, 32'd1, 32'd1);
        check("drain_accum_ready", accum_ready, 0);
        check("drain_readout_ready", readout_ready, 0);
        tick();
        fc_data_valid = 1'b0;
        check("drain_busy_readout_ready", readout_ready, 0);
        for (int n = 0; n < 16 && !readout_ready; n++) tick();
        check("drain_done_readout_ready", readout_ready, 1);
        check("pkt_count_8", pkt_count, 8);

        // Packet during READOUT is dropped
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd30, 32'd9, 32'd9, 32'd9);
        tick();
        fc_data_valid = 1'b0;
        check("drop_err_set", drop_err, 1);
        check("drop_pkt_count", pkt_count, 8);

        rd_cycle(7'd5, f3(32'd11, 32'd22, 32'd33));
        rd_cycle(7'd5, '0);
        // 4 x 0x7FFFFFFF wraps to 0xFFFFFFFC; 4 x -1 = -4
        rd_cycle(7'd9, f3(32'd4, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        rd_cycle(7'd30, '0);
        readout_done = 1'b1;
        rd_cycle(7'd20, f3(32'd6, 32'd7, 32'd8));
        rd_en = 1'b0; readout_done = 1'b0;
        check("done_with_read_accum", accum_ready, 1);
        check("done_with_read_readout", readout_ready, 0);
        tick();

        // rd_en outside READOUT: ignored, no read-clear, rd_data holds
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd50, 32'd2, 32'd2, 32'd2);
        tick();
        fc_data_valid = 1'b0;
        fc_data_in = pkt(7'd5, 32'd1, 32'd1, 32'd1);
        rd_en = 1'b1; rd_addr = 7'd50;
        tick();
        rd_en = 1'b0;
        check("ignored_rd_valid", rd_valid, 0);
        check("ignored_rd_hold", rd_data, last_exp);
        fc_data_valid = 1'b1;
        tick();
        fc_data_valid = 1'b0;
        repeat (2) tick();
        enter_readout();
        rd_cycle(7'd5, f3(32'd1, 32'd1, 32'd1));
        rd_cycle(7'd50, f3(32'd2, 32'd2, 32'd2));
        rd_en = 1'b0;
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;

        // Put data back, then clear_req + readout_req with packets in flight
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd40, 32'd3, 32'd3, 32'd3);
        tick();
        fc_data_valid = 1'b1; fc_data_in = pkt(7'd5, 32'd7, 32'd7, 32'd7);
        tick();
        clear_req = 1'b1; readout_req = 1'b1;
        fc_data_in = pkt(7'd40, 32'd3, 32'd3, 32'd3);
        tick();
        clear_req = 1'b0; readout_req = 1'b0; fc_data_valid = 1'b0;
        check("clear_wins_accum", accum_ready, 0);
        check("clear_wins_readout", readout_ready, 0);
        check("clear_pkt_count", pkt_count, 0);
        check("clear_drop_err", drop_err, 0);
        for (int n = 0; n < 200 && !accum_ready; n++) tick();
        check("reclear_accum_ready", accum_ready, 1);
        enter_readout();
        read_all_zero();
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        check("final_pkt_count", pkt_count, 0);
        check("final_drop_err", drop_err, 0);

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
